// File: rtl/mvu_out_stream.sv
// mvu_out_stream: buffers PE-wide accumulator vectors from the MVU core,
// saturates each lane to OUTPUT_WIDTH and streams the vector out over
// AXI-Stream, OUT_LANES lanes per beat. The core enable is derived from
// buffer occupancy so the core never loses a vector under back-pressure.
module mvu_out_stream #(
  parameter int PE           = 16,
  parameter int ACCU_WIDTH   = 58,
  parameter int OUTPUT_WIDTH = 32,
  parameter int OUT_LANES    = 4,
  parameter int DEPTH        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              en,
  input  logic                              vld,
  input  logic [PE*ACCU_WIDTH-1:0]          p,
  output logic [OUT_LANES*OUTPUT_WIDTH-1:0] m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int BEATS  = PE / OUT_LANES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  // Vector storage; data is never reset, only the control around it.
  logic [PE*ACCU_WIDTH-1:0] r_buf [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [BEAT_W-1:0] r_beat;

  logic                     w_push;
  logic                     w_hs;
  logic                     w_last_beat;
  logic                     w_pop;
  logic [PE*ACCU_WIDTH-1:0] w_head;

  // Clamp one signed accumulator lane to the signed output range. The lane
  // fits exactly when every bit from the output sign bit upward agrees.
  function automatic logic signed [OUTPUT_WIDTH-1:0] sat_lane(
    input logic signed [ACCU_WIDTH-1:0] x
  );
    logic [ACCU_WIDTH-OUTPUT_WIDTH:0] hi;
    hi = x[ACCU_WIDTH-1:OUTPUT_WIDTH-1];
    if ((hi == '0) || (&hi))
      sat_lane = x[OUTPUT_WIDTH-1:0];
    else if (x[ACCU_WIDTH-1])
      sat_lane = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    else
      sat_lane = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  endfunction

  // Enable depends only on registered occupancy, never on tready, so there is
  // no combinational path from the stream sink back into the core.
  assign en            = !rst && (r_count < CNT_FULL);
  assign m_axis_tvalid = (r_count != '0);
  assign w_last_beat   = (r_beat == BEAT_LAST);
  assign m_axis_tlast  = m_axis_tvalid && w_last_beat;
  assign w_push        = vld && en;
  assign w_hs          = m_axis_tvalid && m_axis_tready;
  assign w_pop         = w_hs && w_last_beat;
  assign w_head        = r_buf[r_rd_ptr];

  // Select the current beat's lanes from the head vector and saturate them.
  always_comb begin
    m_axis_tdata = '0;
    for (int k = 0; k < BEATS; k++) begin
      if (r_beat == k[BEAT_W-1:0]) begin
        for (int j = 0; j < OUT_LANES; j++) begin
          m_axis_tdata[j*OUTPUT_WIDTH +: OUTPUT_WIDTH] =
            sat_lane($signed(w_head[(k*OUT_LANES+j)*ACCU_WIDTH +: ACCU_WIDTH]));
        end
      end
    end
  end

  // Capture an accepted core vector into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push)
      r_buf[r_wr_ptr] <= p;
  end

  // Pointer, occupancy and beat bookkeeping; reset discards everything held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_beat   <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_hs)
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mvu_out_stream.sv
// Testbench for mvu_out_stream: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the output stream.
module tb_mvu_out_stream;

  localparam int PE    = 16;
  localparam int AW    = 58;
  localparam int OW    = 32;
  localparam int OL    = 4;
  localparam int DEPTH = 4;
  localparam int BEATS = PE / OL;

  typedef logic [PE*AW-1:0] vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           vld;
  vec_t           p;
  logic [OL*OW-1:0] tdata;
  logic           tvalid;
  logic           tready;
  logic           tlast;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t mq[$];
  int   mbeat  = 0;

  always #5 clk = ~clk;

  mvu_out_stream #(
    .PE(PE), .ACCU_WIDTH(AW), .OUTPUT_WIDTH(OW), .OUT_LANES(OL), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .vld(vld), .p(p),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint lane(input vec_t v, input int i);
    logic signed [AW-1:0] s;
    s = v[i*AW +: AW];
    return longint'(s);
  endfunction

  function automatic logic [OW-1:0] msat(input longint x);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (OW-1)) - 1;
    mn = -(longint'(1) <<< (OW-1));
    if (x > mx) return mx[OW-1:0];
    if (x < mn) return mn[OW-1:0];
    return x[OW-1:0];
  endfunction

  function automatic logic [OL*OW-1:0] exp_tdata();
    logic [OL*OW-1:0] e;
    e = '0;
    for (int j = 0; j < OL; j++)
      e[j*OW +: OW] = msat(lane(mq[0], mbeat*OL + j));
    return e;
  endfunction

  function automatic vec_t set_lane(input vec_t v, input int i, input longint x);
    vec_t r;
    r = v;
    r[i*AW +: AW] = x[AW-1:0];
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t   v;
    longint b;
    logic [63:0] r;
    v = '0;
    for (int i = 0; i < PE; i++) begin
      case ($urandom % 3)
        0: begin r = {$urandom, $urandom}; b = longint'(r); end
        1: b = longint'($signed($urandom));
        default: begin
          case ($urandom % 8)
            0: b = 64'sd2147483647;
            1: b = 64'sd2147483648;
            2: b = -64'sd2147483648;
            3: b = -64'sd2147483649;
            4: b = (longint'(1) <<< 57) - 1;
            5: b = -(longint'(1) <<< 57);
            6: b = 0;
            default: b = -1;
          endcase
        end
      endcase
      v = set_lane(v, i, b);
    end
    return v;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model with
  // whatever transfers the current inputs imply at the next rising edge.
  task automatic cycle();
    logic do_push;
    logic do_hs;
    logic e_en;
    logic e_tv;
    @(negedge clk);
    e_en = !rst && (mq.size() < DEPTH);
    e_tv = (mq.size() != 0);
    chk("en", en, e_en);
    chk("tvalid", tvalid, e_tv);
    chk("tlast", tlast, e_tv && (mbeat == BEATS-1));
    if (e_tv) chk("tdata", tdata, exp_tdata());
    do_push = vld && e_en;
    do_hs   = e_tv && tready;
    @(posedge clk);
    if (do_hs) begin
      if (mbeat == BEATS-1) begin
        mbeat = 0;
        mq.delete(0);
      end else begin
        mbeat++;
      end
    end
    if (do_push) mq.push_back(p);
    #1;
  endtask

  // Asserts reset between clock edges, checks the immediate output response,
  // then releases it just after a rising edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    vld = 1'b0;
    #1;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_en", en, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    mq.delete();
    mbeat = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t ramp;
    vec_t satv;
    int   pushed;
    int   cyc;
    logic acc;

    ramp = '0;
    for (int i = 0; i < PE; i++) ramp = set_lane(ramp, i, longint'(i - 8));
    satv = '0;
    satv = set_lane(satv, 0, longint'(1) <<< 40);
    satv = set_lane(satv, 1, -(longint'(1) <<< 40));
    satv = set_lane(satv, 2, 64'sd2147483647);
    satv = set_lane(satv, 3, -64'sd2147483648);

    rst = 1'b1; vld = 1'b0; tready = 1'b0; p = '0;
    #1;
    chk("init_en", en, 1'b0);
    chk("init_tvalid", tvalid, 1'b0);
    chk("init_tlast", tlast, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single ramp vector, always-ready sink
    tready = 1'b1; p = ramp; vld = 1'b1;
    cycle();
    vld = 1'b0;
    chk("ramp_beat0", tdata, 128'hFFFFFFFB_FFFFFFFA_FFFFFFF9_FFFFFFF8);
    repeat (6) cycle();

    // Saturation of out-of-range lanes
    p = satv; vld = 1'b1;
    cycle();
    vld = 1'b0;
    chk("sat_beat0", tdata, 128'h80000000_7FFFFFFF_80000000_7FFFFFFF);
    repeat (6) cycle();

    // Fill under back-pressure; fifth vector must be refused
    tready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      p = rand_vec(); vld = 1'b1;
      cycle();
    end
    vld = 1'b0;
    chk("full_en", en, 1'b0);
    tready = 1'b1;
    repeat (20) cycle();

    // Randomized vld / tready over 64 accepted vectors
    pushed = 0; cyc = 0; vld = 1'b0;
    while (pushed < 64 && cyc < 4000) begin
      tready = ($urandom % 100) >= 40;
      acc = vld && en;
      cycle();
      if (acc) pushed++;
      if (!(vld && !acc)) begin
        vld = ($urandom % 100) < 60;
        if (vld) p = rand_vec();
      end
      cyc++;
    end
    chk("rand_pushed", pushed, 64);
    vld = 1'b0; tready = 1'b1;
    cyc = 0;
    while (mq.size() != 0 && cyc < 200) begin
      cycle();
      cyc++;
    end
    cycle();

    // Simultaneous push and last-beat pop at occupancy 2, write pointer at 3
    async_reset();
    tready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      p = rand_vec(); vld = 1'b1;
      cycle();
    end
    vld = 1'b0; tready = 1'b1;
    repeat (7) cycle();
    p = rand_vec(); vld = 1'b1;
    cycle();
    vld = 1'b0; tready = 1'b0;
    cycle();
    chk("pp_en_cnt2", en, 1'b1);
    p = rand_vec(); vld = 1'b1;
    cycle();
    chk("pp_en_cnt3", en, 1'b1);
    p = rand_vec();
    cycle();
    vld = 1'b0;
    chk("pp_en_cnt4", en, 1'b0);
    tready = 1'b1;
    repeat (20) cycle();

    // Async reset in the middle of a vector (beat 2, three vectors held)
    async_reset();
    tready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      p = rand_vec(); vld = 1'b1;
      cycle();
    end
    vld = 1'b0; tready = 1'b1;
    repeat (2) cycle();
    async_reset();
    tready = 1'b0;
    cycle();
    tready = 1'b1; p = ramp; vld = 1'b1;
    cycle();
    vld = 1'b0;
    chk("post_rst_beat0", tdata, 128'hFFFFFFFB_FFFFFFFA_FFFFFFF9_FFFFFFF8);
    chk("post_rst_tlast0", tlast, 1'b0);
    repeat (6) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mvu_out_stream.md
Name: mvu_out_stream

Overview:
- Downstream stage of the MVU compute core (mvu_8sx9).
- Captures each PE-wide accumulator vector presented on p with vld. Buffers up to DEPTH vectors.
- Saturates each lane to OUTPUT_WIDTH and serializes the vector onto an AXI-Stream master, OUT_LANES lanes per beat.
- Generates the core's global enable en from buffer occupancy, so core back-pressure is lossless.

Parameters:
- PE, 16, accumulator lanes per core output vector.
- ACCU_WIDTH, 58, signed width of each core accumulator lane.
- OUTPUT_WIDTH, 32, signed width of each output lane after saturation; 2 <= OUTPUT_WIDTH <= ACCU_WIDTH.
- OUT_LANES, 4, lanes per AXI-Stream beat; PE % OUT_LANES == 0.
- DEPTH, 4, buffer capacity in whole vectors; power of two, >= 2.

Ports:
- clk, in, 1, single clock.
- rst, in, 1, reset: asynchronous, active-high.
- en, out, 1, enable to core; core pipeline advances only when en=1.
- vld, in, 1, core output valid; qualified by en.
- p, in, PE*ACCU_WIDTH, core output vector; lane i = p[i*ACCU_WIDTH +: ACCU_WIDTH], signed.
- m_axis_tdata, out, OUT_LANES*OUTPUT_WIDTH, output beat; lane j in bits [j*OUTPUT_WIDTH +: OUTPUT_WIDTH].
- m_axis_tvalid, out, 1, beat valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tlast, out, 1, high on the final beat of each vector.

Behaviour:
- Reset (async assert, released synchronously to clk by system): count=0, wr_ptr=rd_ptr=0, beat=0. m_axis_tvalid=0, m_axis_tlast=0, en=0 while rst=1. m_axis_tdata don't-care.
- en = !rst && (count < DEPTH). Combinational from registered count only; no dependence on m_axis_tready.
- Push: vld && en at a rising edge writes p into buffer[wr_ptr], wr_ptr++ (mod DEPTH), count++. vld with en=0 is ignored; core holds its output in that case.
- Beats per vector: BEATS = PE/OUT_LANES. Beat counter beat in 0..BEATS-1.
- m_axis_tvalid = (count != 0), registered-count based. The first beat appears the cycle after the push edge; push-to-first-beat latency is 1 cycle.
- Beat data: lane j of beat k = sat(buffer[rd_ptr] lane k*OUT_LANES+j).
- sat(x): if x > 2^(OUTPUT_WIDTH-1)-1, output max positive; if x < -2^(OUTPUT_WIDTH-1), output min negative; else x truncated to OUTPUT_WIDTH (exact).
- m_axis_tlast = m_axis_tvalid && (beat == BEATS-1).
- Beat handshake (tvalid && tready):
  - If beat < BEATS-1: beat++.
  - Otherwise: beat=0, rd_ptr++, count-- (pop).
- While tvalid && !tready, tdata and tlast are held stable (head and beat unchanged).
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Full (count==DEPTH): en=0, so no push. A pop at that edge drops count, and en rises the next cycle. No combinational full-bypass.
- Empty: tvalid=0, beat held at 0. A push into an empty buffer is not forwarded in the same cycle.
- BEATS==1: every beat has tlast=1 and pops.
- Reset mid-operation: buffered vectors and any partial vector are discarded. After reset, the stream restarts at beat 0 of the next captured vector.
- Pointers wrap modulo DEPTH; count range is 0..DEPTH inclusive, width clog2(DEPTH)+1.

Test Plan:
- Single vector, PE=16, OUT_LANES=4, tready=1. Lane i = i-8.
  - Expect 4 beats on consecutive cycles starting 1 cycle after push: beat0 lanes {-8,-7,-6,-5} … beat3 {4,5,6,7}.
  - tlast only on beat 3; count returns to 0.
- Saturation, OUTPUT_WIDTH=32. Lanes 0..3 = {2^40, -2^40, 2^31-1, -2^31}.
  - Expect {0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0x80000000}.
- Back-pressure fill: tready=0, push DEPTH=4 vectors with vld=1 each cycle.
  - en drops the cycle after the 4th push; a 5th vld is not captured.
  - Then tready=1: 16 beats in order; en rises the cycle after the first vector's last beat handshake.
- Random tready (~40% low) with random vld over 64 vectors with signed random lanes.
  - Scoreboard: every beat matches the saturated golden value, in order.
  - tdata and tlast stable whenever tvalid && !tready; no vector lost or duplicated.
- Simultaneous push/pop at count=2: vld=1 with a last-beat handshake in the same cycle.
  - Expect count stays 2 and both pointers advance (wr_ptr wraps 3 to 0 when started at 3).
- Async reset asserted mid-vector (beat=2, count=3), between clock edges.
  - Expect tvalid=0 and en=0 immediately; after release en=1, count=0.
  - The next pushed vector is emitted from beat 0.
